// File: rtl/arith_sub_pkg.sv
// Shared types and helpers for the sequential carry-lookahead subtractor.
package arith_sub_pkg;

    // Bits handled per cycle unless the instantiating module overrides it.
    localparam int unsigned CHUNK_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sub_state_t;

    // Number of CLA slices needed to cover a given operand width.
    function automatic int unsigned nchunks(input int unsigned width,
                                            input int unsigned chunk = CHUNK_DEFAULT);
        return width / chunk;
    endfunction

endpackage

// File: rtl/cla_sub_slice.sv
// One CHUNK-wide carry-lookahead slice, purely combinational.
// Computes a + b_n + cin, where b_n is the already inverted subtrahend chunk.
// msb_cin is the carry into the top bit, used for signed overflow detection.
module cla_sub_slice
    import arith_sub_pkg::*;
#(
    parameter int unsigned CHUNK = CHUNK_DEFAULT
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b_n,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);

    logic [CHUNK-1:0] gen;
    logic [CHUNK-1:0] prop;
    logic [CHUNK:0]   carry;

    assign gen  = a & b_n;
    assign prop = a ^ b_n;

    // Carry into bit n as a flat sum of products over generate/propagate terms,
    // so no carry depends on the previous carry bit.
    function automatic logic lookahead(input logic [CHUNK-1:0] g,
                                       input logic [CHUNK-1:0] p,
                                       input logic             ci,
                                       input int               n);
        logic acc;
        logic pchain;
        acc    = 1'b0;
        pchain = 1'b1;
        for (int j = int'(CHUNK) - 1; j >= 0; j--) begin
            if (j < n) begin
                acc    = acc | (g[j] & pchain);
                pchain = pchain & p[j];
            end
        end
        return acc | (pchain & ci);
    endfunction

    for (genvar i = 0; i <= CHUNK; i++) begin : g_carry
        assign carry[i] = lookahead(gen, prop, cin, i);
    end

    assign sum     = prop ^ carry[CHUNK-1:0];
    assign cout    = carry[CHUNK];
    assign msb_cin = carry[CHUNK-1];

endmodule

// File: rtl/seq_u_cla_sub.sv
// Multi-cycle unsigned subtractor: diff = a - b (mod 2^WIDTH) with borrow-out.
// One CHUNK-wide CLA slice is reused each cycle, LSB chunk first, with the
// carry chain held in a register between cycles.
// Define SEQ_SUB_OVF_EN to add the ovf port (signed two's-complement overflow).
module seq_u_cla_sub
    import arith_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = CHUNK_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SEQ_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NCHUNKS = nchunks(WIDTH, CHUNK);
    localparam int unsigned IDX_W   = (NCHUNKS > 1) ? $clog2(NCHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNKS - 1);

    if ((WIDTH % CHUNK) != 0) begin : g_bad_width
        $error("seq_u_cla_sub: WIDTH must be a multiple of CHUNK");
    end

    sub_state_t       state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             borrow_q;
`ifdef SEQ_SUB_OVF_EN
    logic             ovf_q;
`endif

    logic [31:0]      base;
    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b_n;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;
`ifdef SEQ_SUB_OVF_EN
    logic             slice_msb_cin;
`else
    logic             unused_msb_cin;
`endif

    // Bit offset of the chunk being processed this cycle.
    assign base      = 32'(idx_q) * CHUNK;
    assign slice_a   = a_q[base +: CHUNK];
    // Subtraction as a + ~b + 1; the +1 enters through carry_q on chunk 0.
    assign slice_b_n = ~b_q[base +: CHUNK];

    cla_sub_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a       (slice_a),
        .b_n     (slice_b_n),
        .cin     (carry_q),
        .sum     (slice_sum),
        .cout    (slice_cout),
`ifdef SEQ_SUB_OVF_EN
        .msb_cin (slice_msb_cin)
`else
        .msb_cin (unused_msb_cin)
`endif
    );

    // FSM, operand capture, chunk-wise result write and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            borrow_q    <= 1'b0;
`ifdef SEQ_SUB_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        idx_q      <= '0;
                        carry_q    <= 1'b1;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    diff_q[base +: CHUNK] <= slice_sum;
                    carry_q               <= slice_cout;
                    idx_q                 <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        // Final carry of a + ~b + 1 is 1 exactly when no borrow occurred.
                        borrow_q    <= ~slice_cout;
`ifdef SEQ_SUB_OVF_EN
                        ovf_q       <= slice_msb_cin ^ slice_cout;
`endif
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
`ifdef SEQ_SUB_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_seq_u_cla_sub.sv
// Self-checking bench for seq_u_cla_sub (WIDTH=16, CHUNK=4).
// Define SEQ_SUB_OVF_EN for both bench and RTL to cover the ovf port.
module tb_seq_u_cla_sub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] diff;
    logic        borrow;
`ifdef SEQ_SUB_OVF_EN
    logic        ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    seq_u_cla_sub #(
        .WIDTH (16),
        .CHUNK (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
`ifdef SEQ_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the operands.
    function automatic logic [15:0] ref_diff(input logic [15:0] x, input logic [15:0] y);
        int d;
        d = (int'(x) - int'(y) + 65536) % 65536;
        return d[15:0];
    endfunction

    function automatic logic ref_borrow(input logic [15:0] x, input logic [15:0] y);
        return x < y;
    endfunction

    function automatic logic ref_ovf(input logic [15:0] x, input logic [15:0] y);
        int sx;
        int sy;
        int r;
        sx = (x >= 16'h8000) ? int'(x) - 65536 : int'(x);
        sy = (y >= 16'h8000) ? int'(y) - 65536 : int'(y);
        r  = sx - sy;
        return (r > 32767) || (r < -32768);
    endfunction

    function automatic logic get_ovf();
`ifdef SEQ_SUB_OVF_EN
        return ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Issue one operation and wait for out_valid; leaves the result on the port.
    task automatic do_op(input logic [15:0] oa, input logic [15:0] ob, input bit rand_rdy,
                         output logic [15:0] od, output logic obr, output logic oov,
                         output int lat, output bit timeout);
        int n;
        n       = 0;
        timeout = 1'b0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) timeout = 1'b1;
        a        = oa;
        b        = ob;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        lat      = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
            if (!out_valid && rand_rdy) out_ready = 1'($urandom % 2);
        end
        if (!out_valid) timeout = 1'b1;
        od  = diff;
        obr = borrow;
        oov = get_ovf();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, out_valid, borrow, get_ovf(), diff} !== {4'b1000, 16'h0000})
            $display("FAIL reset_state: got rdy=%b vld=%b br=%b ovf=%b diff=%h want 1 0 0 0 0000",
                     in_ready, out_valid, borrow, get_ovf(), diff);
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [15:0] d;
        logic br, ov;
        int lat;
        bit to;
        out_ready = 1'b1;
        do_op(16'h1234, 16'h0034, 1'b0, d, br, ov, lat, to);
        n_checks++;
        if (to !== 1'b0 || lat != 4)
            $display("FAIL basic_latency: got lat=%0d timeout=%b want lat=4", lat, to);
        else n_pass++;
        n_checks++;
        if ({d, br} !== {16'h1200, 1'b0})
            $display("FAIL basic_result: got diff=%h br=%b want 1200 0", d, br);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL basic_one_cycle: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_boundaries();
        logic [15:0] ta [4] = '{16'h0000, 16'h8000, 16'hBEEF, 16'h0000};
        logic [15:0] tb [4] = '{16'h0001, 16'h0001, 16'hBEEF, 16'hFFFF};
        logic [15:0] d;
        logic br, ov;
        int lat;
        bit to;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], 1'b0, d, br, ov, lat, to);
            n_checks++;
            if (to || {d, br} !== {ref_diff(ta[i], tb[i]), ref_borrow(ta[i], tb[i])})
                $display("FAIL boundary_%0d: got diff=%h br=%b to=%b want %h %b", i, d, br, to,
                         ref_diff(ta[i], tb[i]), ref_borrow(ta[i], tb[i]));
            else n_pass++;
`ifdef SEQ_SUB_OVF_EN
            n_checks++;
            if (ov !== ref_ovf(ta[i], tb[i]))
                $display("FAIL boundary_ovf_%0d: got %b want %b", i, ov, ref_ovf(ta[i], tb[i]));
            else n_pass++;
`endif
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        logic [15:0] d;
        logic br, ov;
        int lat;
        bit to;
        out_ready = 1'b0;
        do_op(16'h5555, 16'h1111, 1'b0, d, br, ov, lat, to);
        n_checks++;
        if (to || {d, br} !== {16'h4444, 1'b0})
            $display("FAIL stall_result: got diff=%h br=%b to=%b want 4444 0", d, br, to);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                in_valid = 1'b1;
                a = 16'hFFFF;
                b = 16'h0000;
            end
            if (i == 4) in_valid = 1'b0;
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, in_ready, borrow, diff} !== {3'b100, 16'h4444})
                $display("FAIL stall_hold_%0d: got vld=%b rdy=%b br=%b diff=%h want 1 0 0 4444",
                         i, out_valid, in_ready, borrow, diff);
            else n_pass++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL stall_release: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        else n_pass++;
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL stall_no_queue: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_mid_run_reset();
        logic [15:0] d;
        logic br, ov;
        int lat;
        bit to;
        out_ready = 1'b1;
        a        = 16'h1234;
        b        = 16'h0001;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++;
        if ({in_ready, out_valid, borrow, diff} !== {3'b100, 16'h0000})
            $display("FAIL midrun_reset: got rdy=%b vld=%b br=%b diff=%h want 1 0 0 0000",
                     in_ready, out_valid, borrow, diff);
        else n_pass++;
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0)
            $display("FAIL midrun_discard: got vld=%b want 0", out_valid);
        else n_pass++;
        do_op(16'hABCD, 16'hABCD, 1'b0, d, br, ov, lat, to);
        n_checks++;
        if (to || lat != 4 || {d, br} !== {16'h0000, 1'b0})
            $display("FAIL midrun_fresh: got diff=%h br=%b lat=%0d to=%b want 0000 0 4",
                     d, br, lat, to);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [15:0] oa, ob, d, ed;
        logic br, ov;
        int lat, stall, sel;
        bit to;
        for (int k = 0; k < 1000; k++) begin
            sel = int'($urandom % 8);
            oa  = 16'($urandom);
            ob  = 16'($urandom);
            if (sel == 0) ob = oa;
            if (sel == 1) begin
                oa = 16'h0000;
                ob = 16'hFFFF;
            end
            ed        = ref_diff(oa, ob);
            out_ready = 1'($urandom % 2);
            do_op(oa, ob, 1'b1, d, br, ov, lat, to);
            n_checks++;
            if (to || lat != 4)
                $display("FAIL rand_latency_%0d: got lat=%0d to=%b want 4", k, lat, to);
            else n_pass++;
            n_checks++;
            if ({d, br} !== {ed, ref_borrow(oa, ob)})
                $display("FAIL rand_result_%0d: a=%h b=%h got diff=%h br=%b want %h %b",
                         k, oa, ob, d, br, ed, ref_borrow(oa, ob));
            else n_pass++;
`ifdef SEQ_SUB_OVF_EN
            n_checks++;
            if (ov !== ref_ovf(oa, ob))
                $display("FAIL rand_ovf_%0d: a=%h b=%h got %b want %b", k, oa, ob, ov,
                         ref_ovf(oa, ob));
            else n_pass++;
`endif
            stall     = int'($urandom % 4);
            out_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                n_checks++;
                if ({out_valid, diff} !== {1'b1, ed})
                    $display("FAIL rand_hold_%0d: got vld=%b diff=%h want 1 %h",
                             k, out_valid, diff, ed);
                else n_pass++;
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            n_checks++;
            if (out_valid !== 1'b0)
                $display("FAIL rand_drain_%0d: got vld=%b want 0", k, out_valid);
            else n_pass++;
            if ($urandom % 2 == 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_stall();
        test_mid_run_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
